// File: rtl/register_file.sv
// Operand register file upstream of the ALU: R1-R4 plus scratch S1-S4 (scratch bank present only when
// REGFILE_SCRATCH_EN is defined). Synchronous writes under a shared function code; combinational read ports.
module register_file #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int unsigned NUM_GP  = 4;
  localparam int unsigned NUM_SCR = 4;
  localparam int unsigned NUM_RD  = NUM_GP + NUM_SCR;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned HALF_W  = 16;

  typedef enum logic [2:0] {
    FUN_DEC       = 3'b000,
    FUN_INC       = 3'b001,
    FUN_LOAD      = 3'b010,
    FUN_CLEAR     = 3'b011,
    FUN_LDB_ZX    = 3'b100,
    FUN_LD_LOHALF = 3'b101,
    FUN_SHIFT_B   = 3'b110,
    FUN_LDH_SX    = 3'b111
  } fun_e;

  fun_e fun_c;
  assign fun_c = fun_e'(FunSel);

  // Next value of one selected register: only its own old value and I are involved.
  function automatic logic [WIDTH-1:0] apply_fun(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] din,
                                                 input fun_e             fun);
    logic [WIDTH-1:0] res;
    res = cur;
    unique case (fun)
      FUN_DEC:       res = cur - WIDTH'(1);
      FUN_INC:       res = cur + WIDTH'(1);
      FUN_LOAD:      res = din;
      FUN_CLEAR:     res = '0;
      FUN_LDB_ZX:    res = WIDTH'(din[BYTE_W-1:0]);
      FUN_LD_LOHALF: res = {cur[WIDTH-1:HALF_W], din[HALF_W-1:0]};
      FUN_SHIFT_B:   res = {cur[WIDTH-BYTE_W-1:0], din[BYTE_W-1:0]};
      FUN_LDH_SX:    res = {{(WIDTH-HALF_W){din[HALF_W-1]}}, din[HALF_W-1:0]};
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] gp_q    [NUM_GP];
  logic [WIDTH-1:0] rd_bank [NUM_RD];

  // General-purpose bank; RegSel bit 3 addresses R1 (index 0).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_GP; k++) gp_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_GP; k++) begin
        if (RegSel[NUM_GP-1-k]) gp_q[k] <= apply_fun(gp_q[k], I, fun_c);
      end
    end
  end

`ifdef REGFILE_SCRATCH_EN
  logic [WIDTH-1:0] scr_q [NUM_SCR];

  // Scratch bank; ScrSel bit 3 addresses S1 (index 0).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_SCR; k++) scr_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_SCR; k++) begin
        if (ScrSel[NUM_SCR-1-k]) scr_q[k] <= apply_fun(scr_q[k], I, fun_c);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_GP; k++)  rd_bank[k] = gp_q[k];
    for (int unsigned k = 0; k < NUM_SCR; k++) rd_bank[NUM_GP+k] = scr_q[k];
  end
`else
  // Without the scratch bank its selects are dropped and its read addresses return zero.
  logic unused_scr_sel;
  assign unused_scr_sel = ^ScrSel;

  always_comb begin
    for (int unsigned k = 0; k < NUM_GP; k++)  rd_bank[k] = gp_q[k];
    for (int unsigned k = 0; k < NUM_SCR; k++) rd_bank[NUM_GP+k] = '0;
  end
`endif

  // Read ports show pre-edge state: no write bypass.
  assign OutA = rd_bank[OutASel];
  assign OutB = rd_bank[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against an array model.
module tb_register_file;

`ifdef REGFILE_SCRATCH_EN
  localparam bit SCR_EN = 1'b1;
`else
  localparam bit SCR_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: index 0-3 = R1-R4, 4-7 = S1-S4.
  logic [31:0] m [8];

  register_file #(.WIDTH(32)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] ref_next(input logic [31:0] old, input logic [31:0] d, input int f);
    case (f)
      0: return old - 32'd1;
      1: return old + 32'd1;
      2: return d;
      3: return 32'd0;
      4: return d & 32'h0000_00FF;
      5: return (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      6: return (old << 8) | (d & 32'h0000_00FF);
      default: return d[15] ? ((d & 32'h0000_FFFF) | 32'hFFFF_0000) : (d & 32'h0000_FFFF);
    endcase
  endfunction

  task automatic model_write(input logic rst, input logic [3:0] rs, input logic [3:0] ss,
                             input logic [2:0] f, input logic [31:0] d);
    if (rst) begin
      for (int k = 0; k < 8; k++) m[k] = 32'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rs[3-k]) m[k] = ref_next(m[k], d, int'(f));
        if (SCR_EN && ss[3-k]) m[4+k] = ref_next(m[4+k], d, int'(f));
      end
    end
  endtask

  // One clock of writes; selects return to idle right after the edge.
  task automatic apply(input logic rst, input logic [3:0] rs, input logic [3:0] ss,
                       input logic [2:0] f, input logic [31:0] d);
    @(negedge Clock);
    Reset = rst; RegSel = rs; ScrSel = ss; FunSel = f; I = d;
    @(posedge Clock);
    #1;
    Reset = 1'b0; RegSel = 4'd0; ScrSel = 4'd0;
    model_write(rst, rs, ss, f, d);
  endtask

  task automatic read_ports(input logic [2:0] a, input logic [2:0] b,
                            output logic [31:0] oa, output logic [31:0] ob);
    @(negedge Clock);
    OutASel = a; OutBSel = b;
    #1;
    oa = OutA; ob = OutB;
  endtask

  task automatic test_reset();
    logic [31:0] oa, ob;
    apply(1'b1, 4'hF, 4'hF, 3'b010, 32'hDEAD_BEEF);
    for (int k = 0; k < 8; k++) begin
      read_ports(3'(k), 3'(7 - k), oa, ob);
      n_cmp++;
      if (oa !== 32'd0) begin n_err++; $display("FAIL reset_init_A[%0d]: got %h expected 00000000", k, oa); end
      n_cmp++;
      if (ob !== 32'd0) begin n_err++; $display("FAIL reset_init_B[%0d]: got %h expected 00000000", 7 - k, ob); end
    end
    apply(1'b0, 4'b1000, 4'b0000, 3'b010, 32'h1234_5678);
    apply(1'b0, 4'b0000, 4'b0001, 3'b010, 32'hFFFF_0000);
    read_ports(3'd0, 3'd7, oa, ob);
    n_cmp++;
    if (oa !== 32'h1234_5678) begin n_err++; $display("FAIL reset_preload_R1: got %h expected 12345678", oa); end
    n_cmp++;
    if (ob !== m[7]) begin n_err++; $display("FAIL reset_preload_S4: got %h expected %h", ob, m[7]); end
    apply(1'b1, 4'hF, 4'h0, 3'b010, 32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      read_ports(3'(k), 3'(k), oa, ob);
      n_cmp++;
      if (oa !== 32'd0 || ob !== 32'd0) begin
        n_err++; $display("FAIL reset_clear[%0d]: got A=%h B=%h expected 00000000", k, oa, ob);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] oa, ob;
    logic [31:0] exp_v [3];
    logic [2:0]  fun_v [3];
    exp_v[0] = 32'h0000_0000; fun_v[0] = 3'b001;
    exp_v[1] = 32'hFFFF_FFFF; fun_v[1] = 3'b000;
    exp_v[2] = 32'hFFFF_FFFE; fun_v[2] = 3'b000;
    apply(1'b0, 4'b0100, 4'b0000, 3'b010, 32'hFFFF_FFFF);
    for (int s = 0; s < 3; s++) begin
      apply(1'b0, 4'b0100, 4'b0000, fun_v[s], 32'h0);
      read_ports(3'd1, 3'd1, oa, ob);
      n_cmp++;
      if (oa !== exp_v[s] || ob !== exp_v[s]) begin
        n_err++; $display("FAIL wrap_step%0d: got A=%h B=%h expected %h", s, oa, ob, exp_v[s]);
      end
    end
  endtask

  task automatic test_partial_loads();
    logic [31:0] oa, ob;
    logic [31:0] exp_v [4];
    logic [2:0]  fun_v [4];
    fun_v[0] = 3'b101; exp_v[0] = 32'hAABB_F1E2;
    fun_v[1] = 3'b110; exp_v[1] = 32'hBBF1_E2E2;
    fun_v[2] = 3'b111; exp_v[2] = 32'hFFFF_F1E2;
    fun_v[3] = 3'b100; exp_v[3] = 32'h0000_00E2;
    apply(1'b0, 4'b0010, 4'b0000, 3'b010, 32'hAABB_CCDD);
    for (int s = 0; s < 4; s++) begin
      apply(1'b0, 4'b0010, 4'b0000, fun_v[s], 32'h0000_F1E2);
      read_ports(3'd2, 3'd2, oa, ob);
      n_cmp++;
      if (oa !== exp_v[s]) begin
        n_err++; $display("FAIL partial_fun%0d: got %h expected %h", fun_v[s], oa, exp_v[s]);
      end
    end
  endtask

  task automatic test_multi_select();
    logic [31:0] oa, ob;
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 4'(1 << (3 - k)), 4'(1 << (3 - k)), 3'b010, 32'h1111_0000 + 32'(k * 17));
    end
    apply(1'b0, 4'b1010, 4'b0001, 3'b010, 32'hCAFE_BABE);
    read_ports(3'd0, 3'd2, oa, ob);
    n_cmp++;
    if (oa !== 32'hCAFE_BABE || ob !== 32'hCAFE_BABE) begin
      n_err++; $display("FAIL multi_R1R3: got A=%h B=%h expected cafebabe", oa, ob);
    end
    for (int k = 0; k < 8; k++) begin
      read_ports(3'(k), 3'(k), oa, ob);
      n_cmp++;
      if (oa !== m[k]) begin n_err++; $display("FAIL multi_hold[%0d]: got %h expected %h", k, oa, m[k]); end
    end
    apply(1'b0, 4'b0000, 4'b0000, 3'($urandom_range(0, 7)), $urandom);
    for (int k = 0; k < 8; k++) begin
      read_ports(3'(k), 3'(7 - k), oa, ob);
      n_cmp++;
      if (oa !== m[k] || ob !== m[7 - k]) begin
        n_err++; $display("FAIL noop_hold[%0d]: got A=%h B=%h expected %h/%h", k, oa, ob, m[k], m[7 - k]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] oa, ob;
    apply(1'b0, 4'b0001, 4'b0000, 3'b010, 32'd5);
    @(negedge Clock);
    OutASel = 3'd3; OutBSel = 3'd3;
    RegSel = 4'b0001; ScrSel = 4'd0; FunSel = 3'b001; I = 32'h0;
    #1;
    n_cmp++;
    if (OutA !== 32'd5 || OutB !== 32'd5) begin
      n_err++; $display("FAIL rdw_before: got A=%h B=%h expected 00000005", OutA, OutB);
    end
    @(posedge Clock);
    #1;
    RegSel = 4'd0;
    model_write(1'b0, 4'b0001, 4'b0000, 3'b001, 32'h0);
    n_cmp++;
    if (OutA !== 32'd6 || OutB !== 32'd6) begin
      n_err++; $display("FAIL rdw_after: got A=%h B=%h expected 00000006", OutA, OutB);
    end
    apply(1'b0, 4'b0000, 4'b0100, 3'b010, 32'h5A5A_0001);
    apply(1'b0, 4'b1000, 4'b0000, 3'b010, 32'h00C0_FFEE);
    read_ports(3'd5, 3'd0, oa, ob);
    n_cmp++;
    if (oa !== m[5] || ob !== 32'h00C0_FFEE) begin
      n_err++; $display("FAIL dual_port: got A=%h B=%h expected %h/00c0ffee", oa, ob, m[5]);
    end
  endtask

  task automatic test_scratch_gating();
    logic [31:0] oa, ob;
    apply(1'b0, 4'b0000, 4'hF, 3'b010, 32'h1);
    read_ports(3'd5, 3'd4, oa, ob);
    n_cmp++;
    if (oa !== (SCR_EN ? 32'h1 : 32'h0)) begin
      n_err++; $display("FAIL scratch_read: got %h expected %h", oa, SCR_EN ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      read_ports(3'(k), 3'(k + 4), oa, ob);
      n_cmp++;
      if (oa !== m[k] || ob !== m[k + 4]) begin
        n_err++; $display("FAIL scratch_gp[%0d]: got A=%h B=%h expected %h/%h", k, oa, ob, m[k], m[k + 4]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] oa, ob, d;
    logic [2:0]  a, b;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: d = 32'hFFFF_FFFF;
        1: d = 32'(($urandom_range(0, 1)) << 15) | 32'(($urandom_range(0, 1)) << 7);
        default: d = $urandom;
      endcase
      apply(($urandom_range(0, 29) == 0), 4'($urandom), 4'($urandom), 3'($urandom), d);
      a = 3'($urandom); b = 3'($urandom);
      read_ports(a, b, oa, ob);
      n_cmp++;
      if (oa !== m[a] || ob !== m[b]) begin
        n_err++; $display("FAIL random[%0d]: sel %0d/%0d got A=%h B=%h expected %h/%h", n, a, b, oa, ob, m[a], m[b]);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; I = 32'h0; FunSel = 3'd0; RegSel = 4'd0; ScrSel = 4'd0;
    OutASel = 3'd0; OutBSel = 3'd0;
    for (int k = 0; k < 8; k++) m[k] = 32'd0;
    test_reset();
    test_wrap();
    test_partial_loads();
    test_multi_select();
    test_read_during_write();
    test_scratch_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Operand register file directly upstream of the 32-bit ALU: holds four general-purpose registers (R1–R4) and four scratch registers (S1–S4) and drives the ALU's `A` and `B` operand buses through two independent read ports. All writes are synchronous, and one function code is applied in parallel to every selected register. The block also receives the ALU result, routed back through the system input mux onto `I`, so it forms the write-back end of the datapath loop.

## Interface
Parameters:
- `WIDTH`, 32, register and bus width. Fixed to 32 to match the ALU operand width.

Ports:
- `Clock`  input  1  system clock; all state updates occur on the rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `I`  input  32  write data (ALU result or external load value).
- `FunSel`  input  3  operation applied to every selected register.
- `RegSel`  input  4  active-high write enables; bit 3 = R1, bit 2 = R2, bit 1 = R3, bit 0 = R4.
- `ScrSel`  input  4  active-high write enables; bit 3 = S1 through bit 0 = S4.
- `OutASel`  input  3  read select for port A: 0–3 = R1–R4, 4–7 = S1–S4.
- `OutBSel`  input  3  read select for port B, same encoding as `OutASel`.
- `OutA`  output  32  port A data; feeds ALU `A`.
- `OutB`  output  32  port B data; feeds ALU `B`.

## Operation
`FunSel` codes, applied to each register Rx whose select bit is 1:
- `000` DEC: Rx ← Rx − 1, mod 2^32.
- `001` INC: Rx ← Rx + 1, mod 2^32.
- `010` LOAD: Rx ← I.
- `011` CLEAR: Rx ← 0.
- `100` LOAD-BYTE-ZX: Rx ← {24'b0, I[7:0]}.
- `101` LOAD-LOW-HALF: Rx[15:0] ← I[15:0]; Rx[31:16] is unchanged.
- `110` SHIFT-IN-BYTE: Rx ← {Rx[23:0], I[7:0]}.
- `111` LOAD-HALF-SX: Rx ← {{16{I[15]}}, I[15:0]}.

Rules:
- Registers whose select bit is 0 hold their value.
- `RegSel` = 0 and `ScrSel` = 0 together is a no-op.
- Any combination of the eight registers may be written in the same cycle. Each register uses only its own old value plus `I`.
- The read ports are combinational from register state. `OutA` and `OutB` may select the same register.
- Wrap-around is not flagged. Flags belong to the ALU only.
  - INC of 0xFFFFFFFF gives 0x00000000.
  - DEC of 0x00000000 gives 0xFFFFFFFF.

## Timing
- Reset: when `Reset` = 1 at a rising edge, all eight registers become 0x00000000 and the select/function inputs are ignored. `OutA` and `OutB` therefore read 0 after the first reset edge.
- Reset asserted mid-sequence (for example during a shift-in-byte run) discards partial values. There is no pending state.
- Write latency is one cycle. The new value is visible on the read ports after the edge that performs the write.
- Read-during-write: in the same cycle as the write, a read of the written register returns the old value. There is no bypass, so an ALU result written back is read by the next instruction one cycle later.
- Read-to-ALU path is combinational. `OutA`/`OutB` settle within the same cycle that `OutASel`/`OutBSel` change.
- The ALU's registered flags update on the same edge as the register write-back.

## Configuration
Macro `REGFILE_SCRATCH_EN`:
- Defined: S1–S4 are implemented exactly as described above.
- Undefined:
  - S1–S4 are not instantiated and `ScrSel` is ignored.
  - `OutASel`/`OutBSel` values 4–7 read 0x00000000.
  - R1–R4 behaviour is identical to the defined build.

## Test plan
- Reset: preload R1 = 0x12345678 and S4 = 0xFFFF0000, then assert `Reset` for one edge with `RegSel` = 4'hF and `FunSel` = LOAD. Required: all eight registers read 0 on both ports.
- Wrap-around:
  - R2 = 0xFFFFFFFF, INC → R2 = 0x00000000.
  - Then DEC twice → R2 = 0xFFFFFFFE.
- Partial loads: R3 = 0xAABBCCDD, `I` = 0x0000F1E2.
  - LOAD-LOW-HALF → 0xAABBF1E2.
  - SHIFT-IN-BYTE → 0xBBF1E2E2.
  - LOAD-HALF-SX → 0xFFFFF1E2.
  - LOAD-BYTE-ZX → 0x000000E2.
- Multi-select and hold:
  - `RegSel` = 4'b1010, `ScrSel` = 4'b0001, LOAD `I` = 0xCAFEBABE. Required: R1, R3 and S4 = 0xCAFEBABE; R2, R4 and S1–S3 unchanged.
  - Then `RegSel` = 0, `ScrSel` = 0 with any `FunSel`: nothing changes.
- Read-during-write:
  - `OutASel` = `OutBSel` = R4 with R4 = 5, and INC R4 in the same cycle. Required: both ports show 5 before the edge and 6 after it.
  - With `OutASel` = S2, `OutBSel` = R1: ports show the two distinct values independently.
- Without `REGFILE_SCRATCH_EN`: LOAD 0x1 with `ScrSel` = 4'hF. Required: `OutASel` = 5 reads 0, and R1–R4 are unaffected.
